// File: rtl/id_pipe_stage_pkg.sv
// Shared decode constants for the lapido ID stage: instruction field positions
// and the output-register action encoding.
package id_pipe_stage_pkg;

  localparam int PC_WIDTH = 32;
  localparam int INSTR_W  = 32;
  localparam int OPCODE_W = 6;
  localparam int FUNCT_W  = 6;
  localparam int IMM_W    = 16;

  localparam int OP_HI = 31, OP_LO = 26;
  localparam int RS_HI = 25, RS_LO = 21;
  localparam int RT_HI = 20, RT_LO = 16;
  localparam int RD_HI = 15, RD_LO = 11;
  localparam int SH_HI = 10, SH_LO = 6;
  localparam int FN_HI = 5,  FN_LO = 0;

  // What the output register does on the next edge.
  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,
    ACT_LOAD  = 2'd1,
    ACT_CLEAR = 2'd2
  } out_act_e;

endpackage

// File: rtl/id_hazard_detect.sv
// Load-use compare: the incoming instruction needs a register that a load in
// EX has not produced yet.
module id_hazard_detect #(
  parameter int RA_W = 5
) (
  input  logic            in_valid,
  input  logic            ex_mem_read,
  input  logic [RA_W-1:0] ex_dst,
  input  logic [RA_W-1:0] rs_in,
  input  logic [RA_W-1:0] rt_in,
  output logic            hazard_stall
);

  assign hazard_stall = in_valid && ex_mem_read && (ex_dst != '0) &&
                        ((ex_dst == rs_in) || (ex_dst == rt_in));

endmodule

// File: rtl/id_pipe_stage.sv
// Decode/operand-fetch stage: register file with WB write-through, load-use
// stall with bubble, flush, and a registered valid/ready output towards EX.
module id_pipe_stage
  import id_pipe_stage_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int PC_W     = PC_WIDTH,
  parameter  int NUM_REGS = 32,
  parameter  int CNT_W    = 16,
  localparam int RA_W     = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSTR_W-1:0]  instruction,
  input  logic [PC_W-1:0]     in_next_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_W-1:0]     out_next_pc,
  output logic [DATA_W-1:0]   rs_data,
  output logic [DATA_W-1:0]   rt_data,
  output logic [RA_W-1:0]     rs,
  output logic [RA_W-1:0]     rt,
  output logic [RA_W-1:0]     rd,
  output logic [OPCODE_W-1:0] opcode,
  output logic [FUNCT_W-1:0]  funct,
  output logic [DATA_W-1:0]   imm,
  input  logic                wb_we,
  input  logic [RA_W-1:0]     wb_addr,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic                ex_mem_read,
  input  logic [RA_W-1:0]     ex_dst,
  input  logic                flush,
  output logic                hazard_stall,
  output logic [CNT_W-1:0]    stall_count
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic [RA_W-1:0]   rs_in, rt_in, rd_in;
  logic [DATA_W-1:0] rs_rd, rt_rd, imm_ext;
  logic              accept, rs_hit, rt_hit;
  logic              unused_shamt;
  out_act_e          act;

  assign rs_in   = RA_W'(instruction[RS_HI:RS_LO]);
  assign rt_in   = RA_W'(instruction[RT_HI:RT_LO]);
  assign rd_in   = RA_W'(instruction[RD_HI:RD_LO]);
  assign imm_ext = {{(DATA_W-IMM_W){instruction[IMM_W-1]}}, instruction[IMM_W-1:0]};
  assign unused_shamt = ^instruction[SH_HI:SH_LO];

  // Reads see a same-cycle WB write so the stage never fetches a stale value.
  assign rs_rd = (rs_in == '0) ? '0 : (wb_we && wb_addr == rs_in) ? wb_data : regs[rs_in];
  assign rt_rd = (rt_in == '0) ? '0 : (wb_we && wb_addr == rt_in) ? wb_data : regs[rt_in];

  id_hazard_detect #(.RA_W(RA_W)) u_hazard (
    .in_valid    (in_valid),
    .ex_mem_read (ex_mem_read),
    .ex_dst      (ex_dst),
    .rs_in       (rs_in),
    .rt_in       (rt_in),
    .hazard_stall(hazard_stall)
  );

  assign in_ready = !flush && !hazard_stall && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // A held instruction keeps tracking WB so EX never consumes a stale operand.
  assign rs_hit = wb_we && (wb_addr == rs) && (rs != '0);
  assign rt_hit = wb_we && (wb_addr == rt) && (rt != '0);

  always_comb begin
    act = ACT_HOLD;
    if (flush)                        act = ACT_CLEAR;
    else if (accept)                  act = ACT_LOAD;
    else if (!out_valid || out_ready) act = ACT_CLEAR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_we && wb_addr != '0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_next_pc <= '0;
      rs_data     <= '0;
      rt_data     <= '0;
      rs          <= '0;
      rt          <= '0;
      rd          <= '0;
      opcode      <= '0;
      funct       <= '0;
      imm         <= '0;
    end else begin
      case (act)
        ACT_LOAD: begin
          out_valid   <= 1'b1;
          out_next_pc <= in_next_pc;
          rs_data     <= rs_rd;
          rt_data     <= rt_rd;
          rs          <= rs_in;
          rt          <= rt_in;
          rd          <= rd_in;
          opcode      <= instruction[OP_HI:OP_LO];
          funct       <= instruction[FN_HI:FN_LO];
          imm         <= imm_ext;
        end
        ACT_CLEAR: out_valid <= 1'b0;
        default: begin
          if (rs_hit) rs_data <= wb_data;
          if (rt_hit) rt_data <= wb_data;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_count <= '0;
    else if (hazard_stall && !flush && stall_count != '1)
      stall_count <= stall_count + 1'b1;
  end

endmodule

// File: doc/id_pipe_stage.md
# id_pipe_stage

Parametrised decode/operand-fetch stage for the lapido core. It sits between IF and EX and holds its own register file. It adds a valid/ready handshake on both sides, load-use hazard stalls with bubble insertion, and a synchronous flush. WB-to-ID write-through bypass and operand refresh while output is held are also handled here, along with a saturating stall counter. The output register feeds `control_unit` (opcode/funct) and EX directly.

## Interface
- `DATA_W`, 32, register/operand width
- `PC_W`, 32, next-PC width (equals `PC_WIDTH`)
- `NUM_REGS`, 32, register count (power of two, ≥2); `RA_W = $clog2(NUM_REGS)`
- `CNT_W`, 16, stall counter width
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: reset, asynchronous, active-high
- `in_valid` in 1 / `in_ready` out 1: IF→ID handshake
- `instruction` in 32; `in_next_pc` in PC_W
- `out_valid` out 1 / `out_ready` in 1: ID→EX handshake
- `out_next_pc` out PC_W; `rs_data`, `rt_data` out DATA_W
- `rs`, `rt`, `rd` out RA_W; `opcode`, `funct` out 6; `imm` out DATA_W (sign-extended instruction[15:0])
- `wb_we` in 1; `wb_addr` in RA_W; `wb_data` in DATA_W: WB write port
- `ex_mem_read` in 1; `ex_dst` in RA_W: instruction currently in EX is a load to `ex_dst`
- `flush` in 1: taken branch/jump resolved; kill ID contents
- `hazard_stall` out 1 (combinational); `stall_count` out CNT_W

## Operation
- Fields decoded from `instruction`: rs=[25:21], rt=[20:16], rd=[15:11], opcode=[31:26], funct=[5:0], imm16=[15:0]. Addresses are truncated/zero-padded to RA_W.
- Register file: NUM_REGS×DATA_W. Reg 0 reads 0, and writes to 0 are ignored. Write occurs on clk edge when `wb_we`.
- Bypass: a read of addr≠0 while `wb_we && wb_addr==addr` returns `wb_data`.
- `hazard_stall = in_valid && ex_mem_read && ex_dst!=0 && (ex_dst==rs_in || ex_dst==rt_in)`.
- `in_ready = !flush && !hazard_stall && (!out_valid || out_ready)`.
- Accept (`in_valid && in_ready`): the output register loads fields, next_pc, imm and bypassed operands; `out_valid<=1`.
- No accept and (`!out_valid || out_ready`): `out_valid<=0`. A stall therefore inserts a bubble.
- Hold (`out_valid && !out_ready && !flush`): contents frozen. Exception: if `wb_we` and `wb_addr==rs` (resp. rt) and ≠0, `rs_data` (resp. `rt_data`) is updated to `wb_data`.
- Flush: highest priority. `out_valid<=0`, no accept that cycle, and the held instruction is discarded. The register-file write still happens.
- `stall_count` increments each cycle `hazard_stall && !flush`, and saturates at all-ones.

## Timing
- Reset: `out_valid`=0; all data/address/imm/opcode/funct outputs 0; every register 0; `stall_count`=0. `in_ready` follows its combinational equation (1 while `out_valid`=0, no hazard, no flush).
- Latency: 1 cycle from accept to `out_valid`. Throughput is 1/cycle when `out_ready` stays high.
- Load-use: stalls exactly while the condition holds, which is normally 1 cycle. The instruction is accepted on the following cycle.
- Simultaneous `flush` and `hazard_stall`: flush wins, and the counter does not increment.
- Reset mid-operation clears state immediately, without waiting for a clock edge.

## Structure
- Shared package/defines (`lapido_defs.v`): field bit positions and opcode width; reuse `PC_WIDTH`.
- One natural sub-module: `id_hazard_detect` (combinational load-use compare, producing `hazard_stall`).
- The register file array and the output register stay inline. The sign extender is inline as well; `ext_de_sinal` is 16→32 only.

## Test plan
- Reset then write r5=0x1234 via WB, then accept `add` rs=5 → next cycle `out_valid`=1, `rs_data`=0x1234.
- Same-cycle WB r7=0xAA and accept rs=7 → `rs_data`=0xAA (bypass). Write to r0 of 0xFF then read r0 → 0.
- `ex_mem_read`=1, `ex_dst`=3, instruction rt=3 → `in_ready`=0, `hazard_stall`=1, bubble (`out_valid`=0), `stall_count`=1. Next cycle with `ex_mem_read`=0 → accepted.
- `out_ready`=0 holding rs=4, WB writes r4=0x55 → `rs_data` becomes 0x55 and other fields are unchanged.
- `flush`=1 with `out_valid`=1 and `in_valid`=1 → `out_valid`=0 next cycle, `in_ready`=0 during the flush. Hazard asserted concurrently → `stall_count` unchanged.
- Force 2^CNT_W+3 hazard cycles → `stall_count` holds at all-ones. Assert `rst` mid-stream → all outputs 0 asynchronously.
